// File: rtl/phase_scan_ctrl_pkg.sv
// Shared encodings for the DCM phase scanner: FSM states, phaser unfire code, DCM zero-shift phase.
package phase_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_FIRE   = 3'd2,
    ST_UNFIRE = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DWELL  = 3'd5,
    ST_EVAL   = 3'd6,
    ST_DONE   = 3'd7
  } scan_state_e;

  // Phaser state-vector value meaning "shift complete, waiting for fire to drop".
  localparam logic [2:0] PS_SM_UNFIRE = 3'h6;

  localparam int PHASE_OFFSET = 32;

endpackage

// File: rtl/phase_scan_ctrl_win.sv
// scan_win_tracker: longest consecutive zero-error run; ties keep the earliest run.
// Only instantiated when PHASE_SCAN_WINDOW_EN is defined.
module scan_win_tracker
  import phase_scan_ctrl_pkg::*;
#(
  parameter int MXPHASE = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               eval_i,
  input  logic               zero_i,
  input  logic [MXPHASE-1:0] phase_i,
  output logic               best_found_o,
  output logic [MXPHASE-1:0] best_phase_o,
  output logic [MXPHASE-1:0] win_len_o
);

  localparam logic [MXPHASE-1:0] PHASE_ZERO = MXPHASE'(PHASE_OFFSET);

  logic               run_act_q;
  logic [MXPHASE-1:0] run_first_q;
  logic [MXPHASE-1:0] run_len_q;
  logic               best_found_q;
  logic [MXPHASE-1:0] best_first_q;
  logic [MXPHASE-1:0] best_last_q;
  logic [MXPHASE-1:0] best_len_q;

  logic [MXPHASE-1:0] cand_first_d;
  logic [MXPHASE-1:0] cand_len_d;
  logic [MXPHASE:0]   mid_sum_d;

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    cand_first_d = phase_i;
    cand_len_d   = MXPHASE'(1);
    if (run_act_q) begin
      cand_first_d = run_first_q;
      cand_len_d   = (run_len_q == '1) ? run_len_q : run_len_q + MXPHASE'(1);
    end
  end

  // NOTE: reset is asynchronous active-low; state updates use <= so all reads see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_act_q    <= 1'b0;
      run_first_q  <= '0;
      run_len_q    <= '0;
      best_found_q <= 1'b0;
      best_first_q <= PHASE_ZERO;
      best_last_q  <= PHASE_ZERO;
      best_len_q   <= '0;
    end else if (clear_i) begin
      run_act_q    <= 1'b0;
      run_first_q  <= '0;
      run_len_q    <= '0;
      best_found_q <= 1'b0;
      best_first_q <= PHASE_ZERO;
      best_last_q  <= PHASE_ZERO;
      best_len_q   <= '0;
    end else if (eval_i) begin
      if (zero_i) begin
        run_act_q   <= 1'b1;
        run_first_q <= cand_first_d;
        run_len_q   <= cand_len_d;
        // Strictly longer only, so an equal later run never displaces the earlier one.
        if (cand_len_d > best_len_q) begin
          best_found_q <= 1'b1;
          best_first_q <= cand_first_d;
          best_last_q  <= phase_i;
          best_len_q   <= cand_len_d;
        end
      end else begin
        run_act_q <= 1'b0;
      end
    end
  end

  assign mid_sum_d    = {1'b0, best_first_q} + {1'b0, best_last_q};
  assign best_phase_o = mid_sum_d[MXPHASE:1];
  assign best_found_o = best_found_q;
  assign win_len_o    = best_len_q;

endmodule

// File: rtl/phase_scan_ctrl.sv
// Automatic DCM phase scanner driving the DPS phaser; reports the best zero-error phase.
// Define PHASE_SCAN_WINDOW_EN to centre on the longest zero-error run instead of the first clean point.
module phase_scan_ctrl
  import phase_scan_ctrl_pkg::*;
#(
  parameter int MXPHASE  = 6,
  parameter int MXDWELL  = 16,
  parameter int MXERRCNT = 8,
  parameter int SETTLE   = 8,
  parameter int TIMEOUT  = 4095
) (
  input  logic                clock,
  input  logic                global_reset_n,
  input  logic                scan_start,
  input  logic                scan_abort,
  input  logic [MXPHASE-1:0]  phase_first,
  input  logic [MXPHASE-1:0]  phase_last,
  input  logic [MXPHASE-1:0]  phase_step,
  input  logic [MXDWELL-1:0]  dwell,
  input  logic                err_in,
  input  logic                ps_busy,
  input  logic [2:0]          ps_sm_vec,
  output logic                ps_fire,
  output logic                ps_reset,
  output logic [MXPHASE-1:0]  ps_phase,
  output logic                scan_busy,
  output logic                scan_done,
  output logic                scan_err,
  output logic [MXPHASE-1:0]  best_phase,
  output logic                best_found,
  output logic [MXPHASE-1:0]  win_len,
  output logic [MXERRCNT-1:0] last_errcnt
);

  localparam int                 TMOW       = $clog2(TIMEOUT + 1);
  localparam logic [MXPHASE-1:0] PHASE_ZERO = MXPHASE'(PHASE_OFFSET);

  scan_state_e         state_q;
  logic                ps_fire_q;
  logic                ps_reset_q;
  logic [MXPHASE-1:0]  ps_phase_q;
  logic                scan_busy_q;
  logic                scan_done_q;
  logic                scan_err_q;
  logic                park_q;
  logic [MXPHASE-1:0]  last_q;
  logic [MXPHASE-1:0]  step_q;
  logic [MXDWELL-1:0]  dwell_q;
  logic [MXDWELL-1:0]  cnt_q;
  logic [TMOW-1:0]     tmo_q;
  logic [MXERRCNT-1:0] errcnt_q;
  logic [MXERRCNT-1:0] last_errcnt_q;

  logic [MXPHASE:0]    next_phase_d;
  logic                scan_end_d;
  logic                timeout_d;
  logic                abort_d;
  logic                clear_d;
  logic                eval_d;
  logic                zero_d;
  logic [MXERRCNT-1:0] errcnt_d;

  logic                best_found_w;
  logic [MXPHASE-1:0]  best_phase_w;
  logic [MXPHASE-1:0]  win_len_w;

  // One extra bit so a step past 63 shows up as a carry rather than wrapping.
  assign next_phase_d = {1'b0, ps_phase_q} + {1'b0, step_q};
  assign scan_end_d   = next_phase_d[MXPHASE] || (next_phase_d[MXPHASE-1:0] > last_q);
  assign timeout_d    = (tmo_q == TMOW'(TIMEOUT - 1));
  assign abort_d      = scan_abort && (state_q != ST_IDLE);
  assign clear_d      = (state_q == ST_IDLE) && scan_start && !scan_abort;
  assign eval_d       = (state_q == ST_EVAL) && !scan_abort;
  assign zero_d       = (errcnt_q == '0);
  assign errcnt_d     = (err_in && (errcnt_q != '1)) ? errcnt_q + MXERRCNT'(1) : errcnt_q;

`ifdef PHASE_SCAN_WINDOW_EN
  scan_win_tracker #(
    .MXPHASE (MXPHASE)
  ) u_win (
    .clk          (clock),
    .rst_n        (global_reset_n),
    .clear_i      (clear_d),
    .eval_i       (eval_d),
    .zero_i       (zero_d),
    .phase_i      (ps_phase_q),
    .best_found_o (best_found_w),
    .best_phase_o (best_phase_w),
    .win_len_o    (win_len_w)
  );
`else
  logic               best_found_q;
  logic [MXPHASE-1:0] best_phase_q;

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      best_found_q <= 1'b0;
      best_phase_q <= PHASE_ZERO;
    end else if (clear_d) begin
      best_found_q <= 1'b0;
      best_phase_q <= PHASE_ZERO;
    end else if (eval_d && zero_d && !best_found_q) begin
      best_found_q <= 1'b1;
      best_phase_q <= ps_phase_q;
    end
  end

  assign best_found_w = best_found_q;
  assign best_phase_w = best_phase_q;
  assign win_len_w    = '0;
`endif

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q       <= ST_IDLE;
      ps_fire_q     <= 1'b0;
      ps_reset_q    <= 1'b0;
      ps_phase_q    <= PHASE_ZERO;
      scan_busy_q   <= 1'b0;
      scan_done_q   <= 1'b0;
      scan_err_q    <= 1'b0;
      park_q        <= 1'b0;
      last_q        <= '0;
      step_q        <= '0;
      dwell_q       <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      errcnt_q      <= '0;
      last_errcnt_q <= '0;
    end else begin
      ps_reset_q <= 1'b0;
      if (abort_d) begin
        ps_fire_q   <= 1'b0;
        ps_reset_q  <= 1'b1;
        scan_busy_q <= 1'b0;
        park_q      <= 1'b0;
        state_q     <= ST_IDLE;
      end else if (((state_q == ST_FIRE) || (state_q == ST_UNFIRE)) && timeout_d) begin
        ps_fire_q  <= 1'b0;
        ps_reset_q <= 1'b1;
        scan_err_q <= 1'b1;
        state_q    <= ST_DONE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (clear_d) begin
              scan_done_q   <= 1'b0;
              scan_err_q    <= 1'b0;
              scan_busy_q   <= 1'b1;
              park_q        <= 1'b0;
              last_errcnt_q <= '0;
              state_q       <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            last_q  <= phase_last;
            step_q  <= (phase_step == '0) ? MXPHASE'(1) : phase_step;
            dwell_q <= (dwell == '0) ? MXDWELL'(1) : dwell;
            if (phase_first > phase_last) begin
              scan_err_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              ps_phase_q <= phase_first;
              ps_fire_q  <= 1'b1;
              tmo_q      <= '0;
              state_q    <= ST_FIRE;
            end
          end
          ST_FIRE: begin
            tmo_q <= tmo_q + TMOW'(1);
            if (ps_sm_vec == PS_SM_UNFIRE) begin
              ps_fire_q <= 1'b0;
              state_q   <= ST_UNFIRE;
            end
          end
          ST_UNFIRE: begin
            tmo_q <= tmo_q + TMOW'(1);
            if (!ps_busy) begin
              cnt_q   <= '0;
              state_q <= park_q ? ST_DONE : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt_q == MXDWELL'(SETTLE - 1)) begin
              cnt_q    <= '0;
              errcnt_q <= '0;
              state_q  <= ST_DWELL;
            end else begin
              cnt_q <= cnt_q + MXDWELL'(1);
            end
          end
          ST_DWELL: begin
            errcnt_q <= errcnt_d;
            if (cnt_q == dwell_q - MXDWELL'(1)) begin
              state_q <= ST_EVAL;
            end else begin
              cnt_q <= cnt_q + MXDWELL'(1);
            end
          end
          ST_EVAL: begin
            last_errcnt_q <= errcnt_q;
            if (scan_end_d) begin
              state_q <= ST_DONE;
            end else begin
              ps_phase_q <= next_phase_d[MXPHASE-1:0];
              ps_fire_q  <= 1'b1;
              tmo_q      <= '0;
              state_q    <= ST_FIRE;
            end
          end
          ST_DONE: begin
            // First pass through DONE parks the phaser on the result, second pass finishes.
            if (best_found_w && !park_q && !scan_err_q) begin
              park_q     <= 1'b1;
              ps_phase_q <= best_phase_w;
              ps_fire_q  <= 1'b1;
              tmo_q      <= '0;
              state_q    <= ST_FIRE;
            end else begin
              scan_done_q <= 1'b1;
              scan_busy_q <= 1'b0;
              park_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ps_fire     = ps_fire_q;
  assign ps_reset    = ps_reset_q;
  assign ps_phase    = ps_phase_q;
  assign scan_busy   = scan_busy_q;
  assign scan_done   = scan_done_q;
  assign scan_err    = scan_err_q;
  assign best_phase  = best_phase_w;
  assign best_found  = best_found_w;
  assign win_len     = win_len_w;
  assign last_errcnt = last_errcnt_q;

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// Directed bench for phase_scan_ctrl with a behavioural phaser responder and error injector.
module tb_phase_scan_ctrl;

  localparam int MXPHASE  = 6;
  localparam int MXDWELL  = 16;
  localparam int MXERRCNT = 8;
  localparam int SETTLE   = 8;
  localparam int TIMEOUT  = 4095;

  logic                clock;
  logic                global_reset_n;
  logic                scan_start;
  logic                scan_abort;
  logic [MXPHASE-1:0]  phase_first;
  logic [MXPHASE-1:0]  phase_last;
  logic [MXPHASE-1:0]  phase_step;
  logic [MXDWELL-1:0]  dwell;
  logic                err_in;
  logic                ps_busy;
  logic [2:0]          ps_sm_vec;
  logic                ps_fire;
  logic                ps_reset;
  logic [MXPHASE-1:0]  ps_phase;
  logic                scan_busy;
  logic                scan_done;
  logic                scan_err;
  logic [MXPHASE-1:0]  best_phase;
  logic                best_found;
  logic [MXPHASE-1:0]  win_len;
  logic [MXERRCNT-1:0] last_errcnt;

  int   checks;
  int   passed;
  int   failed;
  int   fire_count;
  int   reset_pulses;
  int   ph_cnt;
  bit   fire_seen;
  bit   stall;
  logic [63:0] err_mask;

`ifdef PHASE_SCAN_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  phase_scan_ctrl #(
    .MXPHASE  (MXPHASE),
    .MXDWELL  (MXDWELL),
    .MXERRCNT (MXERRCNT),
    .SETTLE   (SETTLE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .scan_start     (scan_start),
    .scan_abort     (scan_abort),
    .phase_first    (phase_first),
    .phase_last     (phase_last),
    .phase_step     (phase_step),
    .dwell          (dwell),
    .err_in         (err_in),
    .ps_busy        (ps_busy),
    .ps_sm_vec      (ps_sm_vec),
    .ps_fire        (ps_fire),
    .ps_reset       (ps_reset),
    .ps_phase       (ps_phase),
    .scan_busy      (scan_busy),
    .scan_done      (scan_done),
    .scan_err       (scan_err),
    .best_phase     (best_phase),
    .best_found     (best_found),
    .win_len        (win_len),
    .last_errcnt    (last_errcnt)
  );

  initial clock = 1'b0;
  always #12 clock = ~clock;

  // Phaser responder and error source, driven on the falling edge.
  initial begin
    ps_busy = 1'b0; ps_sm_vec = 3'h0; err_in = 1'b0;
    ph_cnt = 0; fire_seen = 1'b0; fire_count = 0; reset_pulses = 0;
    forever begin
      @(negedge clock);
      if (ps_reset === 1'b1) begin
        reset_pulses++;
        ps_busy = 1'b0; ps_sm_vec = 3'h0; fire_seen = 1'b0;
      end else if (ps_fire === 1'b1 && !fire_seen) begin
        fire_count++;
        fire_seen = 1'b1; ps_busy = 1'b1; ph_cnt = 0;
      end else if (ps_fire === 1'b1 && fire_seen && !stall) begin
        ph_cnt++;
        if (ph_cnt >= 3) ps_sm_vec = 3'h6;
      end else if (ps_fire === 1'b0 && fire_seen && !stall) begin
        ps_sm_vec = 3'h0; ps_busy = 1'b0; fire_seen = 1'b0;
      end
      err_in = scan_busy && err_mask[ps_phase];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    scan_start = 1'b1;
    tick(1);
    scan_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int cyc, output bit expired);
    cyc = 0;
    expired = 1'b0;
    while (scan_busy === 1'b1 && cyc < max_cyc) begin
      tick(1);
      cyc++;
    end
    expired = (scan_busy !== 1'b0);
  endtask

  int cyc;
  bit expired;
  int f0;
  int r0;

  initial begin
    checks = 0; passed = 0; failed = 0;
    stall = 1'b0; err_mask = '0;
    global_reset_n = 1'b0; scan_start = 1'b0; scan_abort = 1'b0;
    phase_first = '0; phase_last = '0; phase_step = '0; dwell = '0;
    tick(3);
    global_reset_n = 1'b1;
    tick(1);

    // Reset state
    check("rst_ps_phase", ps_phase, 32);
    check("rst_best_phase", best_phase, 32);
    check("rst_ps_fire", ps_fire, 0);
    check("rst_ps_reset", ps_reset, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_err", scan_err, 0);
    check("rst_found", best_found, 0);
    check("rst_win_len", win_len, 0);
    check("rst_errcnt", last_errcnt, 0);

    // Bad range: error within two cycles, phaser never fired
    f0 = fire_count;
    phase_first = 6'd40; phase_last = 6'd20; phase_step = 6'd4; dwell = 16'd4;
    pulse_start();
    check("badrange_busy", scan_busy, 1);
    tick(1);
    check("badrange_err", scan_err, 1);
    tick(1);
    check("badrange_done", scan_done, 1);
    check("badrange_idle", scan_busy, 0);
    check("badrange_nofire", fire_count - f0, 0);

    // 20..40 step 4, errors at 20, 24, 40; start pulse mid-scan must be ignored
    f0 = fire_count;
    err_mask = '0;
    err_mask[20] = 1'b1; err_mask[24] = 1'b1; err_mask[40] = 1'b1;
    phase_first = 6'd20; phase_last = 6'd40; phase_step = 6'd4; dwell = 16'd4;
    pulse_start();
    tick(30);
    pulse_start();
    wait_idle(2000, cyc, expired);
    check("scan1_timeout", expired, 0);
    check("scan1_done", scan_done, 1);
    check("scan1_err", scan_err, 0);
    check("scan1_found", best_found, 1);
    check("scan1_best", best_phase, WIN_EN ? 32 : 28);
    check("scan1_win_len", win_len, WIN_EN ? 3 : 0);
    check("scan1_parked", ps_phase, WIN_EN ? 32 : 28);
    check("scan1_errcnt", last_errcnt, 4);
    check("scan1_fires", fire_count - f0, 7);

    // Single point at the top of range, step 0 and dwell 0 both act as 1
    f0 = fire_count;
    err_mask = '0;
    phase_first = 6'd63; phase_last = 6'd63; phase_step = 6'd0; dwell = 16'd0;
    pulse_start();
    wait_idle(500, cyc, expired);
    check("top_timeout", expired, 0);
    check("top_done", scan_done, 1);
    check("top_err", scan_err, 0);
    check("top_best", best_phase, 63);
    check("top_win_len", win_len, WIN_EN ? 1 : 0);
    check("top_ps_phase", ps_phase, 63);
    check("top_fires", fire_count - f0, 2);

    // Every point errors for 300 cycles: counter saturates, nothing found, phaser left at last point
    f0 = fire_count;
    err_mask = '1;
    phase_first = 6'd60; phase_last = 6'd63; phase_step = 6'd1; dwell = 16'd300;
    pulse_start();
    wait_idle(3000, cyc, expired);
    check("allerr_timeout", expired, 0);
    check("allerr_done", scan_done, 1);
    check("allerr_found", best_found, 0);
    check("allerr_best", best_phase, 32);
    check("allerr_win_len", win_len, 0);
    check("allerr_ps_phase", ps_phase, 63);
    check("allerr_errcnt_sat", last_errcnt, 255);
    check("allerr_fires", fire_count - f0, 4);

    // Abort during dwell (start asserted alongside must lose)
    f0 = fire_count;
    r0 = reset_pulses;
    err_mask = '0;
    phase_first = 6'd5; phase_last = 6'd5; phase_step = 6'd1; dwell = 16'd100;
    pulse_start();
    cyc = 0;
    while (!(fire_count == f0 + 1 && !fire_seen) && cyc < 100) begin
      tick(1);
      cyc++;
    end
    check("abort_phaser_wait", cyc < 100, 1);
    tick(SETTLE + 3);
    check("abort_pre_busy", scan_busy, 1);
    scan_abort = 1'b1; scan_start = 1'b1;
    tick(1);
    scan_abort = 1'b0; scan_start = 1'b0;
    check("abort_reset_hi", ps_reset, 1);
    check("abort_idle", scan_busy, 0);
    check("abort_fire_lo", ps_fire, 0);
    check("abort_done", scan_done, 0);
    tick(1);
    check("abort_reset_lo", ps_reset, 0);
    check("abort_pulses", reset_pulses - r0, 1);
    check("abort_still_idle", scan_busy, 0);
    check("abort_err", scan_err, 0);

    // Phaser never reaches unfire: timeout, one reset pulse, fire dropped
    f0 = fire_count;
    r0 = reset_pulses;
    stall = 1'b1;
    phase_first = 6'd10; phase_last = 6'd10; phase_step = 6'd1; dwell = 16'd1;
    pulse_start();
    wait_idle(6000, cyc, expired);
    check("tmo_timeout", expired, 0);
    check("tmo_latency", (cyc >= TIMEOUT) && (cyc <= TIMEOUT + 8), 1);
    check("tmo_err", scan_err, 1);
    check("tmo_done", scan_done, 1);
    check("tmo_fire_lo", ps_fire, 0);
    tick(2);
    check("tmo_pulses", reset_pulses - r0, 1);
    check("tmo_fires", fire_count - f0, 1);
    stall = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
